// File: rtl/cpu_control_unit_pkg.sv
// Shared definitions for the CPU control unit: opcodes, ALU select codes,
// FSM state encoding, instruction field positions and the opcode decoder.
package cpu_control_unit_pkg;

    typedef enum logic {
        ST_EXEC = 1'b0,
        ST_MEM  = 1'b1
    } state_t;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;
    localparam logic [7:0] OP_MULT  = 8'h0C;
    localparam logic [7:0] OP_SLL   = 8'h0D;
    localparam logic [7:0] OP_SRL   = 8'h0E;
    localparam logic [7:0] OP_SRA   = 8'h0F;
    localparam logic [7:0] OP_ROR   = 8'h10;
    localparam logic [7:0] OP_BNE   = 8'h11;

    localparam logic [2:0] ALU_FWD  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_MULT = 3'b100;
    localparam logic [2:0] ALU_LSH  = 3'b101;
    localparam logic [2:0] ALU_ASH  = 3'b110;
    localparam logic [2:0] ALU_ROT  = 3'b111;

    localparam int OPCODE_LSB = 24;
    localparam int OFFSET_LSB = 16;
    localparam int WADDR_LSB  = 16;
    localparam int RADDR1_LSB = 8;
    localparam int RADDR2_LSB = 0;
    localparam int IMM_LSB    = 0;

    typedef struct packed {
        logic       legal;
        logic [2:0] aluop;
        logic       negate;
        logic       imm_sel;
        logic       reg_write;
        logic       is_load;
        logic       is_store;
        logic       is_jump;
        logic       is_beq;
        logic       is_bne;
    } decode_t;

    // Undefined opcodes decode to an all-zero NOP with legal cleared.
    function automatic decode_t decode_opcode(input logic [7:0] opcode);
        decode_t d;
        d       = '0;
        d.legal = 1'b1;
        case (opcode)
            OP_LOADI: begin d.imm_sel = 1'b1; d.reg_write = 1'b1; end
            OP_MOV:   d.reg_write = 1'b1;
            OP_ADD:   begin d.aluop = ALU_ADD; d.reg_write = 1'b1; end
            OP_SUB:   begin d.aluop = ALU_ADD; d.negate = 1'b1; d.reg_write = 1'b1; end
            OP_AND:   begin d.aluop = ALU_AND; d.reg_write = 1'b1; end
            OP_OR:    begin d.aluop = ALU_OR; d.reg_write = 1'b1; end
            OP_J:     d.is_jump = 1'b1;
            OP_BEQ:   begin d.aluop = ALU_ADD; d.negate = 1'b1; d.is_beq = 1'b1; end
            OP_BNE:   begin d.aluop = ALU_ADD; d.negate = 1'b1; d.is_bne = 1'b1; end
            OP_LWD:   d.is_load = 1'b1;
            OP_LWI:   begin d.is_load = 1'b1; d.imm_sel = 1'b1; end
            OP_SWD:   d.is_store = 1'b1;
            OP_SWI:   begin d.is_store = 1'b1; d.imm_sel = 1'b1; end
            OP_MULT:  begin d.aluop = ALU_MULT; d.reg_write = 1'b1; end
            OP_SLL:   begin d.aluop = ALU_LSH; d.imm_sel = 1'b1; d.reg_write = 1'b1; end
            OP_SRL:   begin d.aluop = ALU_LSH; d.negate = 1'b1; d.imm_sel = 1'b1; d.reg_write = 1'b1; end
            OP_SRA:   begin d.aluop = ALU_ASH; d.negate = 1'b1; d.imm_sel = 1'b1; d.reg_write = 1'b1; end
            OP_ROR:   begin d.aluop = ALU_ROT; d.negate = 1'b1; d.imm_sel = 1'b1; d.reg_write = 1'b1; end
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cpu_control_unit_pc_next_unit.sv
// Next-PC computation: sequential PC+4 or the PC-relative jump/branch target,
// chosen from the opcode class and the ALU zero flag.
module cpu_control_unit_pc_next_unit #(
    parameter int PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [7:0]          offset,
    input  logic                is_jump,
    input  logic                is_beq,
    input  logic                is_bne,
    input  logic                zero,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [PC_WIDTH-1:0] pc_next
);

    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] target;
    logic                taken;

    // Offset counts words, so it is sign-extended and scaled by 4.
    assign offset_ext = {{(PC_WIDTH-10){offset[7]}}, offset, 2'b00};
    assign pc_plus4   = pc + PC_WIDTH'(4);
    assign target     = pc_plus4 + offset_ext;
    assign taken      = is_jump | (is_beq & zero) | (is_bne & ~zero);
    assign pc_next    = taken ? target : pc_plus4;

endmodule

// File: rtl/cpu_control_unit.sv
// Sequential control unit: owns the PC, decodes instructions into register-file
// and ALU controls, and sequences data-memory accesses with a BUSYWAIT stall.
module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [31:0]         INSTRUCTION,
    input  logic                ZERO,
    input  logic                BUSYWAIT,
    output logic [PC_WIDTH-1:0] PC,
    output logic [2:0]          ALUOP,
    output logic                NEGATE,
    output logic                IMM_SEL,
    output logic [7:0]          IMMEDIATE,
    output logic [2:0]          WRITE_ADDR,
    output logic [2:0]          READ_ADDR1,
    output logic [2:0]          READ_ADDR2,
    output logic                REG_WRITE,
    output logic                MEM_TO_REG,
    output logic                MEM_READ,
    output logic                MEM_WRITE,
    output logic                ILLEGAL
);

    state_t              state_reg, state_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    logic [PC_WIDTH-1:0] pc_plus4, pc_target;
    logic                illegal_reg, illegal_next;
    decode_t             dec;
    logic                unused_src1_hi;

    assign dec            = decode_opcode(INSTRUCTION[OPCODE_LSB +: 8]);
    assign unused_src1_hi = ^INSTRUCTION[15:11];

    assign PC         = pc_reg;
    assign ILLEGAL    = illegal_reg;
    assign ALUOP      = dec.aluop;
    assign NEGATE     = dec.negate;
    assign IMM_SEL    = dec.imm_sel;
    assign IMMEDIATE  = INSTRUCTION[IMM_LSB +: 8];
    assign WRITE_ADDR = INSTRUCTION[WADDR_LSB +: 3];
    assign READ_ADDR1 = INSTRUCTION[RADDR1_LSB +: 3];
    assign READ_ADDR2 = INSTRUCTION[RADDR2_LSB +: 3];

    cpu_control_unit_pc_next_unit #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next (
        .pc       (pc_reg),
        .offset   (INSTRUCTION[OFFSET_LSB +: 8]),
        .is_jump  (dec.is_jump),
        .is_beq   (dec.is_beq),
        .is_bne   (dec.is_bne),
        .zero     (ZERO),
        .pc_plus4 (pc_plus4),
        .pc_next  (pc_target)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg   <= ST_EXEC;
            pc_reg      <= RESET_PC;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        illegal_next = illegal_reg | ((state_reg == ST_EXEC) & ~dec.legal);
        REG_WRITE    = 1'b0;
        MEM_TO_REG   = 1'b0;
        MEM_READ     = 1'b0;
        MEM_WRITE    = 1'b0;

        case (state_reg)
            ST_EXEC: begin
                // Memory ops launch regardless of BUSYWAIT so the strobe never
                // depends combinationally on the memory's own stall output.
                if (dec.is_load | dec.is_store) begin
                    MEM_READ   = dec.is_load;
                    MEM_WRITE  = dec.is_store;
                    state_next = ST_MEM;
                end else if (!BUSYWAIT) begin
                    REG_WRITE = dec.reg_write;
                    pc_next   = pc_target;
                end
            end
            default: begin
                MEM_READ  = dec.is_load;
                MEM_WRITE = dec.is_store;
                if (!BUSYWAIT) begin
                    REG_WRITE  = dec.is_load;
                    MEM_TO_REG = dec.is_load;
                    pc_next    = pc_plus4;
                    state_next = ST_EXEC;
                end
            end
        endcase

        // Enables must drop the instant reset is asserted, not at the next edge.
        if (!RESET_N) begin
            REG_WRITE  = 1'b0;
            MEM_TO_REG = 1'b0;
            MEM_READ   = 1'b0;
            MEM_WRITE  = 1'b0;
        end
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
Sequential control unit for the 8-bit single-issue CPU. It owns the 32-bit PC, decodes each instruction into register-file addresses and ALU controls (SELECT code, operand negate, immediate select), and resolves branch/jump using the ALU ZERO flag. It sequences data-memory access with a BUSYWAIT stall. It sits between instruction memory and the register file / ALU / data memory.

Parameters:
PC_WIDTH, 32, PC and address width
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  in  1  system clock, rising-edge
RESET_N  in  1  asynchronous active-low reset
INSTRUCTION  in  32  {OPCODE[31:24], DEST/OFFSET[23:16], SRC1[15:8], SRC2/IMM[7:0]}
ZERO  in  1  ALU zero flag, valid during EXEC
BUSYWAIT  in  1  data-memory stall
PC  out  PC_WIDTH  current instruction address
ALUOP  out  3  ALU SELECT: 000 fwd, 001 add, 010 and, 011 or, 100 mult, 101 logical shift, 110 arith shift, 111 rotate
NEGATE  out  1  two's-complement DATA2 before the ALU (sub, right shifts/rotate, beq/bne)
IMM_SEL  out  1  DATA2 = IMMEDIATE rather than register
IMMEDIATE  out  8  INSTRUCTION[7:0]
WRITE_ADDR / READ_ADDR1 / READ_ADDR2  out  3 each  INSTRUCTION[18:16] / [10:8] / [2:0]
REG_WRITE  out  1  register-file write enable
MEM_TO_REG  out  1  write-back source = memory
MEM_READ / MEM_WRITE  out  1 each  data-memory strobes
ILLEGAL  out  1  sticky: undefined opcode seen

Behaviour:
- Opcodes: 00 loadi, 01 mov, 02 add, 03 sub, 04 and, 05 or, 06 j, 07 beq, 08 lwd, 09 lwi, 0A swd, 0B swi, 0C mult, 0D sll, 0E srl, 0F sra, 10 ror, 11 bne.
- ALUOP/NEGATE map: sub=001/1; sll=101/0; srl=101/1; sra=110/1; ror=111/1; beq/bne=001/1. All other ALU ops use NEGATE=0.
- IMM_SEL=1 for loadi, lwi, swi; IMMEDIATE also carries the shift amount for shifts and rotate.
- Reset (async, RESET_N low): PC=RESET_PC, state=EXEC, ILLEGAL=0, REG_WRITE=MEM_READ=MEM_WRITE=0.
- Decode outputs are combinational from INSTRUCTION and state; only PC, state and ILLEGAL are registered.
- FSM states:
  - EXEC: non-memory op. REG_WRITE=1 for ALU and load-immediate ops; PC updates on the next rising edge (1-cycle latency).
  - lwd/lwi/swd/swi in EXEC: assert MEM_READ (loads) or MEM_WRITE (stores), hold PC, go to MEM.
  - MEM: hold the strobe, PC and the decode outputs while BUSYWAIT=1. The first edge with BUSYWAIT=0 advances PC and returns to EXEC. Loads assert REG_WRITE and MEM_TO_REG during that final MEM cycle.
- Next PC:
  - default PC+4;
  - j: PC+4+(sext(OFFSET)<<2);
  - beq taken when ZERO=1, bne taken when ZERO=0, same target.
  - PC arithmetic wraps modulo 2^PC_WIDTH.
- BUSYWAIT high in EXEC (late stall from the previous access) holds PC and suppresses REG_WRITE.
- Undefined opcode: treated as NOP (all enables 0, PC+4), and ILLEGAL sets and stays set until reset.
- Reset mid-MEM: strobes drop immediately (async), FSM returns to EXEC, PC=RESET_PC.
- Branch offset −1 (0xFF) gives PC+4−4 = PC, a legal self-loop.

Decomposition:
- Shared package: opcode constants, ALUOP codes, state encoding, instruction field bit positions.
- One natural sub-module, pc_next_unit: combinational PC+4 / branch target adder and select, driven by opcode class and ZERO.

Test Plan:
- Reset release with PC=0, instruction loadi r2,0x05 -> ALUOP=000, IMM_SEL=1, REG_WRITE=1, WRITE_ADDR=2; PC=4 after one edge.
- sub r3,r1,r2 then srl r4,r1,0x02 -> ALUOP=001/NEGATE=1, then ALUOP=101/NEGATE=1/IMM_SEL=1; PC 4->8->12.
- beq offset 0x02 at PC=0x10, ZERO=1 -> PC=0x1C; same with ZERO=0 -> PC=0x14; bne with ZERO=0 -> 0x1C.
- lwd r1,r2 at PC=0x20, BUSYWAIT high for 3 cycles -> MEM_READ held 4 cycles, PC stays 0x20, REG_WRITE+MEM_TO_REG only in the final cycle, then PC=0x24.
- swi with RESET_N pulsed low during MEM -> MEM_WRITE drops immediately, PC=0 and state EXEC after release.
- Opcode 0x3F -> no enables asserted, ILLEGAL=1 persisting, PC+4; j offset 0xFF -> PC unchanged.
